spi_serf: RTL and testbench

Responder side of the 16-bit SPI link used throughout the flight controller. It sits on the peripheral side of the bus and serves as the bench model of the inertial sensor and as the on-board responder for the command link. It synchronizes SS_n, SCLK and MOSI into the clk domain and shifts a 16-bit word in on MOSI while shifting a 16-bit word out on MISO. At frame end it presents the received word with a sticky ready flag. The bus is SCLK-idle-high: data is sampled and shifted on SCLK rise, and the initiator samples MISO one clk after each rise.

---
 rtl/spi_serf.sv | 130 +++++++++++++
 tb/tb_spi_serf.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_serf.sv
// -----------------------------------------------------------------------------
// spi_serf : 16-bit SPI responder (SCLK idles high, sample/shift on SCLK rise)
//
// Synchronizes SS_n, SCLK and MOSI into the clk domain. The responder shifts a
// 16-bit word in on MOSI while shifting the word captured from tx_data out on
// MISO, MSB first. When a frame ends, the received word is presented on
// rx_data and the sticky rdy flag is set.
//
// Optional feature (compile-time macro SPI_SERF_FRM_CHK_EN):
//   defined   : a frame that does not carry exactly 16 SCLK rises pulses
//               frm_err for one clk and leaves rx_data and rdy untouched.
//   undefined : every frame end loads rx_data and sets rdy; frm_err stays 0.
//
// Ports
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   SS_n     in   bus select, low for the length of a frame
//   SCLK     in   bus clock, idles high
//   MOSI     in   serial data from the initiator, MSB first
//   MISO     out  serial data to the initiator; high-Z while SS_n pin is high
//   tx_data  in   word to return, captured at the detected SS_n fall
//   clr_rdy  in   one-cycle pulse that clears rdy
//   rx_data  out  last complete word received
//   rdy      out  sticky frame-received flag
//   frm_err  out  one-cycle pulse on a bad frame length
//
// Handshake: rdy/rx_data behave as a level-valid pair. rdy rises at the end of
// an accepted frame and stays high until clr_rdy or the next detected SS_n
// fall; rx_data is stable whenever rdy is high.
// -----------------------------------------------------------------------------
module spi_serf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [15:0] tx_data,
    input  logic        clr_rdy,
    output logic [15:0] rx_data,
    output logic        rdy,
    output logic        frm_err
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t      state;
    logic [2:0]  ss_ff;
    logic [2:0]  sclk_ff;
    logic [1:0]  mosi_ff;
    logic [15:0] shft_reg;
    logic [4:0]  bit_cnt;

    logic ss_fall;
    logic ss_rise;
    logic sclk_rise;

    // Edge detects look at stages 2 and 3 so the first stage can settle.
    assign ss_fall   =  ss_ff[2]   & ~ss_ff[1];
    assign ss_rise   = ~ss_ff[2]   &  ss_ff[1];
    assign sclk_rise = ~sclk_ff[2] &  sclk_ff[1];

    // MISO follows the raw pin so the bus is released without sync delay.
    assign MISO = SS_n ? 1'bz : shft_reg[15];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_ff   <= 3'b111;
            sclk_ff <= 3'b111;
            mosi_ff <= 2'b00;
        end else begin
            ss_ff   <= {ss_ff[1:0], SS_n};
            sclk_ff <= {sclk_ff[1:0], SCLK};
            mosi_ff <= {mosi_ff[0], MOSI};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shft_reg <= 16'h0000;
            bit_cnt  <= 5'd0;
            rx_data  <= 16'h0000;
            rdy      <= 1'b0;
            frm_err  <= 1'b0;
        end else begin
            frm_err <= 1'b0;
            // Assignments further down override this, so a set wins over clear.
            if (clr_rdy) begin
                rdy <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (ss_fall) begin
                        shft_reg <= tx_data;
                        bit_cnt  <= 5'd0;
                        rdy      <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (ss_rise) begin
                        state <= IDLE;
`ifdef SPI_SERF_FRM_CHK_EN
                        if (bit_cnt == 5'd16) begin
                            rx_data <= shft_reg;
                            rdy     <= 1'b1;
                        end else begin
                            frm_err <= 1'b1;
                        end
`else
                        rx_data <= shft_reg;
                        rdy     <= 1'b1;
`endif
                    end else if (sclk_rise) begin
                        if (bit_cnt < 5'd16) begin
                            shft_reg <= {shft_reg[14:0], mosi_ff[1]};
                            bit_cnt  <= bit_cnt + 5'd1;
                        end else begin
                            // Extra clocks mark the frame as long; no shifting.
                            bit_cnt <= 5'd17;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_serf.sv
// -----------------------------------------------------------------------------
// tb_spi_serf : bench for spi_serf. Drives SPI frames as the initiator and
// compares frame results (rdy / frm_err with rx_data) against a word-level
// model through an expected queue.
// Queue entry: bit 16 = frame expected to be flagged bad, bits 15:0 = rx_data.
// -----------------------------------------------------------------------------
module tb_spi_serf;

    logic        clk;
    logic        rst_n;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    wire         MISO;
    logic [15:0] tx_data;
    logic        clr_rdy;
    logic [15:0] rx_data;
    logic        rdy;
    logic        frm_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [16:0] exp_q[$];

    // Initiator-side model of the frame in progress.
    logic [15:0] cur_tx;
    logic [15:0] cur_word;
    logic [15:0] miso_word;
    int          cur_n;
    logic [15:0] last_rx;

    spi_serf dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO),
        .tx_data (tx_data),
        .clr_rdy (clr_rdy),
        .rx_data (rx_data),
        .rdy     (rdy),
        .frm_err (frm_err)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial begin
        #4000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- driver tasks ----------------
    task automatic frame_start(input logic [15:0] tx);
        @(negedge clk);
        tx_data   = tx;
        SS_n      = 1'b0;
        cur_tx    = tx;
        cur_word  = tx;
        miso_word = 16'h0000;
        cur_n     = 0;
        wait_neg(4);
    endtask

    task automatic clock_bit(input logic b);
        SCLK = 1'b0;
        MOSI = b;
        wait_neg(8);
        SCLK = 1'b1;
        wait_neg(1);
        if (cur_n < 16) begin
            check("miso_bit", {31'd0, MISO}, {31'd0, cur_tx[15 - cur_n]});
            miso_word = {miso_word[14:0], MISO};
            cur_word  = {cur_word[14:0], b};
        end
        cur_n++;
        wait_neg(7);
    endtask

    // Push the expected outcome, raise SS_n and check the 3-clk result latency.
    task automatic frame_end();
`ifdef SPI_SERF_FRM_CHK_EN
        if (cur_n == 16) begin
            exp_q.push_back({1'b0, cur_word});
            last_rx = cur_word;
        end else begin
            exp_q.push_back({1'b1, last_rx});
        end
`else
        exp_q.push_back({1'b0, cur_word});
        last_rx = cur_word;
`endif
        SS_n = 1'b1;
        wait_neg(2);
        check("evt_early", {31'd0, rdy | frm_err}, 32'd0);
        wait_neg(1);
        check("evt_at_3clk", {31'd0, rdy | frm_err}, 32'd1);
        wait_neg(5);
    endtask

    task automatic send_frame(input logic [15:0] tx, input logic [15:0] data, input int n);
        frame_start(tx);
        for (int i = 0; i < n; i++) begin
            clock_bit(data[15 - (i % 16)]);
        end
        frame_end();
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic rdy_prev = 1'b0;
    logic err_prev = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            rdy_prev <= 1'b0;
            err_prev <= 1'b0;
        end else begin
            if (frm_err && err_prev) begin
                check("frm_err_width", 32'd2, 32'd1);
            end
            if ((rdy && !rdy_prev) || frm_err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", {15'd0, frm_err, rx_data}, 32'hFFFF_FFFF);
                end else begin
                    logic [16:0] e;
                    e = exp_q.pop_front();
                    check("evt_kind", {31'd0, frm_err}, {31'd0, e[16]});
                    check("rx_data", {16'd0, rx_data}, {16'd0, e[15:0]});
                    if (e[16]) begin
                        check("err_rdy_low", {31'd0, rdy}, 32'd0);
                    end
                end
            end
            rdy_prev <= rdy;
            err_prev <= frm_err;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] save_rx;
        logic        save_rdy;

        rst_n   = 1'b0;
        SS_n    = 1'b1;
        SCLK    = 1'b1;
        MOSI    = 1'b0;
        tx_data = 16'h0000;
        clr_rdy = 1'b0;
        last_rx = 16'h0000;
        cur_tx  = 16'h0000;
        cur_word = 16'h0000;
        miso_word = 16'h0000;
        cur_n   = 0;

        wait_neg(3);
        check("rst_rdy", {31'd0, rdy}, 32'd0);
        check("rst_rx", {16'd0, rx_data}, 32'd0);
        check("rst_err", {31'd0, frm_err}, 32'd0);
        rst_n = 1'b1;
        wait_neg(4);

        // Good frame.
        send_frame(16'hA5C3, 16'h3C5A, 16);
        check("good_miso_word", {16'd0, miso_word}, 32'h0000_A5C3);
        check("good_rdy", {31'd0, rdy}, 32'd1);

        // Back-to-back frames without clr_rdy.
        send_frame(16'h0F0F, 16'h1234, 16);
        check("b2b_rdy_hold", {31'd0, rdy}, 32'd1);
        frame_start(16'h7E81);
        check("b2b_rdy_drop", {31'd0, rdy}, 32'd0);
        for (int i = 0; i < 16; i++) clock_bit(1'b1);
        frame_end();
        check("b2b_rx", {16'd0, rx_data}, 32'h0000_FFFF);
        pulse_clr();
        check("clr_rdy", {31'd0, rdy}, 32'd0);
        check("clr_rx_keep", {16'd0, rx_data}, 32'h0000_FFFF);

        // Length boundaries: short, long, empty.
        send_frame(16'h1357, 16'hC3A5, 8);
        send_frame(16'h2468, 16'h5AA5, 17);
        send_frame(16'h9999, 16'h0000, 0);
        send_frame(16'hFACE, 16'h6E6E, 15);

        // Bus idle: SCLK toggles with SS_n high.
        save_rx  = rx_data;
        save_rdy = rdy;
        for (int i = 0; i < 20; i++) begin
            SCLK = ~SCLK;
            MOSI = 1'($urandom_range(0, 1));
            wait_neg(8);
        end
        SCLK = 1'b1;
        wait_neg(4);
        check("idle_rx", {16'd0, rx_data}, {16'd0, save_rx});
        check("idle_rdy", {31'd0, rdy}, {31'd0, save_rdy});
        send_frame(16'h4321, 16'h8001, 16);

        // Randomized frames.
        for (int k = 0; k < 40; k++) begin
            int n;
            n = ($urandom_range(0, 9) < 8) ? 16 : int'($urandom_range(0, 20));
            send_frame(16'($urandom), 16'($urandom), n);
            if ($urandom_range(0, 3) == 0) begin
                pulse_clr();
                check("rand_clr", {31'd0, rdy}, 32'd0);
            end
        end

        // Reset in the middle of a frame.
        frame_start(16'h1111);
        for (int i = 0; i < 5; i++) clock_bit(1'b1);
        rst_n = 1'b0;
        wait_neg(1);
        check("midrst_rdy", {31'd0, rdy}, 32'd0);
        check("midrst_rx", {16'd0, rx_data}, 32'd0);
        check("midrst_err", {31'd0, frm_err}, 32'd0);
        last_rx = 16'h0000;
        tx_data = 16'h5A5A;
        wait_neg(3);
        // SS_n is still low, so leaving reset starts a zero-length frame.
        rst_n    = 1'b1;
        cur_tx   = 16'h5A5A;
        cur_word = 16'h5A5A;
        cur_n    = 0;
        wait_neg(6);
        frame_end();
`ifdef SPI_SERF_FRM_CHK_EN
        check("postrst_rdy", {31'd0, rdy}, 32'd0);
`else
        check("postrst_rdy", {31'd0, rdy}, 32'd1);
`endif
        send_frame(16'hC0DE, 16'hBEEF, 16);
        check("beef_rx", {16'd0, rx_data}, 32'h0000_BEEF);
        check("beef_miso_word", {16'd0, miso_word}, 32'h0000_C0DE);

        wait_neg(10);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
